sram_port_arbiter: RTL

//  Shares the single 16-bit asynchronous off-chip SRAM between two requesters:

---
 rtl/sram_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async 16-bit SRAM between a high-priority pixel read port (p0) and a CPU read/write port (p1)
// Ports: clk, reset_n (async, active low); p0_req/p0_addr -> p0_ack/p0_rdata (reads only);
//   p1_req/p1_we/p1_addr/p1_wdata/p1_be -> p1_ack/p1_rdata; sram_addr, sram_dq_in/out/oe and
//   active-low sram_ce_n/oe_n/we_n/ub_n/lb_n go to the SRAM pads. All outputs are registered.
module sram_port_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_P0_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam int SW = $clog2(MAX_P0_BURST + 1);
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     streak_q;
  logic              owner_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q, rdata0_q, rdata1_q;
  logic              ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q, ack0_q, ack1_q;
  logic              pick_p1, wr_d;
  // p1 takes the slot only when p0 is idle or has used up its burst allowance
  assign pick_p1 = p1_req && (!p0_req || streak_q == SW'(MAX_P0_BURST));
  assign wr_d    = pick_p1 && p1_we;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // a p1 request that loses here can only lose to p0 below the cap, so +1 never overshoots
          streak_q <= (p1_req && !pick_p1) ? streak_q + 1'b1 : '0;
          if (p0_req || p1_req) begin
            state_q <= ACCESS;
            cnt_q   <= CW'(ACCESS_CYCLES - 1);
            owner_q <= pick_p1;
            wr_q    <= wr_d;
            addr_q  <= pick_p1 ? p1_addr : p0_addr;
            if (wr_d) dq_out_q <= p1_wdata;
            ce_n_q  <= 1'b0;
            oe_n_q  <= wr_d;
            we_n_q  <= !wr_d;
            dq_oe_q <= wr_d;
            ub_n_q  <= wr_d && !p1_be[1];
            lb_n_q  <= wr_d && !p1_be[0];
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ack0_q  <= !owner_q;
            ack1_q  <= owner_q;
            if (!wr_q && !owner_q) rdata0_q <= sram_dq_in;
            if (!wr_q && owner_q) rdata1_q <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // strobes went high last edge; address and write data were held through this cycle
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign p0_ack      = ack0_q;
  assign p0_rdata    = rdata0_q;
  assign p1_ack      = ack1_q;
  assign p1_rdata    = rdata1_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;
endmodule
